// File: rtl/edit_ctl.sv
// edit_ctl: front-panel edit controller.
// Debounces MODE/NEXT/INC buttons, runs the VIEW/EDIT/RD/WR page and field
// editor, and does read-modify-write of packed-BCD bytes in the display RAM.
// Optional INC auto-repeat is built only when EDIT_CTL_AUTOREPEAT_EN is defined.
`timescale 1ns/1ps

module edit_ctl #(
    parameter int         DEB_N = 11,
    parameter int         PAGES = 4,
    parameter logic [7:0] LIM0  = 8'h59,
    parameter logic [7:0] LIM1  = 8'h59,
    parameter logic [7:0] LIM2  = 8'h23
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [2:0] btn,
    output logic [1:0] page,
    output logic [5:0] blink_mask,
    output logic       edit_active,
    output logic [3:0] ram_raddr,
    input  logic [7:0] ram_r,
    output logic [3:0] ram_waddr,
    output logic [7:0] ram_wdata,
    output logic       ram_we
);

    typedef enum logic [1:0] {
        ST_VIEW = 2'd0,
        ST_EDIT = 2'd1,
        ST_RD   = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    // Packed-BCD maximum of the field being edited.
    function automatic logic [7:0] lim_sel(input logic [1:0] field);
        logic [7:0] lim;
        case (field)
            2'd0:    lim = LIM0;
            2'd1:    lim = LIM1;
            2'd2:    lim = LIM2;
            default: lim = 8'h00;
        endcase
        return lim;
    endfunction

    // One BCD increment step with wrap at the field limit; invalid BCD clears.
    function automatic logic [7:0] bcd_step(input logic [7:0] x, input logic [7:0] lim);
        logic [7:0] y;
        if ((x[7:4] > 4'd9) || (x[3:0] > 4'd9)) begin
            y = 8'h00;
        end else if (x == lim) begin
            y = 8'h00;
        end else if (x[3:0] == 4'd9) begin
            y = {x[7:4] + 4'd1, 4'h0};
        end else begin
            y = x + 8'd1;
        end
        return y;
    endfunction

    // Two adjacent digits blink for the selected field.
    function automatic logic [5:0] blink_for(input logic [1:0] field);
        return 6'b000011 << {field, 1'b0};
    endfunction

    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [DEB_N-1:0] r_tick_cnt;
    logic             w_tick;
    logic [2:0]       r_samp;
    logic [2:0]       r_pressed;
    logic [2:0]       r_pulse;
    logic             w_inc_raw;
    logic             w_mode_p;
    logic             w_next_p;
    logic             w_inc_p;
    logic [1:0]       w_page_inc;

    state_t           r_state;
    logic [1:0]       r_page;
    logic [1:0]       r_field;
    logic [5:0]       r_blink;
    logic             r_edit;
    logic [3:0]       r_raddr;
    logic [3:0]       r_waddr;
    logic [7:0]       r_wdata;
    logic             r_we;

    // Two-flop synchronizer for the asynchronous buttons (released = 1).
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_sync1 <= 3'b111;
            r_sync2 <= 3'b111;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running sample-period counter.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + DEB_N'(1);
        end
    end

    assign w_tick = &r_tick_cnt;

    // Debounce: two equal consecutive samples change the accepted state;
    // each accepted press emits a single-cycle pulse.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_samp    <= 3'b111;
            r_pressed <= 3'b000;
            r_pulse   <= 3'b000;
        end else begin
            r_pulse <= 3'b000;
            if (w_tick) begin
                r_samp <= r_sync2;
                for (int i = 0; i < 3; i++) begin
                    if (!r_pressed[i] && !r_sync2[i] && !r_samp[i]) begin
                        r_pressed[i] <= 1'b1;
                        r_pulse[i]   <= 1'b1;
                    end else if (r_pressed[i] && r_sync2[i] && r_samp[i]) begin
                        r_pressed[i] <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef EDIT_CTL_AUTOREPEAT_EN
    logic [4:0] r_rep_cnt;
    logic       r_rep_p;

    // INC auto-repeat: first extra pulse after 16 held ticks, then every 4.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_rep_cnt <= 5'd0;
            r_rep_p   <= 1'b0;
        end else begin
            r_rep_p <= 1'b0;
            if (w_tick) begin
                if (r_pressed[2] && !r_sync2[2]) begin
                    if (r_rep_cnt == 5'd15) begin
                        r_rep_p   <= 1'b1;
                        r_rep_cnt <= 5'd12;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + 5'd1;
                    end
                end else begin
                    r_rep_cnt <= 5'd0;
                end
            end
        end
    end

    assign w_inc_raw = r_pulse[2] | r_rep_p;
`else
    assign w_inc_raw = r_pulse[2];
`endif

    // MODE beats NEXT beats INC when pulses coincide.
    assign w_mode_p = r_pulse[0];
    assign w_next_p = r_pulse[1] & ~r_pulse[0];
    assign w_inc_p  = w_inc_raw & ~r_pulse[0] & ~r_pulse[1];

    assign w_page_inc = (r_page == 2'(PAGES - 1)) ? 2'd0 : (r_page + 2'd1);

    // Page/field editor. ram_raddr tracks {page, field} whenever they change,
    // so the RAM already returns the selected byte during RD; the new value
    // is registered at the RD->WR edge and written with ram_we high in WR.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= ST_VIEW;
            r_page  <= 2'd0;
            r_field <= 2'd0;
            r_blink <= 6'd0;
            r_edit  <= 1'b0;
            r_raddr <= 4'd0;
            r_waddr <= 4'd0;
            r_wdata <= 8'd0;
            r_we    <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_VIEW: begin
                    if (w_mode_p) begin
                        r_page  <= w_page_inc;
                        r_raddr <= {w_page_inc, 2'd0};
                    end else if (w_next_p) begin
                        r_state <= ST_EDIT;
                        r_field <= 2'd0;
                        r_blink <= blink_for(2'd0);
                        r_edit  <= 1'b1;
                        r_raddr <= {r_page, 2'd0};
                    end
                end
                ST_EDIT: begin
                    if (w_mode_p) begin
                        r_state <= ST_VIEW;
                        r_field <= 2'd0;
                        r_blink <= 6'd0;
                        r_edit  <= 1'b0;
                        r_raddr <= {r_page, 2'd0};
                    end else if (w_next_p) begin
                        if (r_field >= 2'd2) begin
                            r_state <= ST_VIEW;
                            r_field <= 2'd0;
                            r_blink <= 6'd0;
                            r_edit  <= 1'b0;
                            r_raddr <= {r_page, 2'd0};
                        end else begin
                            r_field <= r_field + 2'd1;
                            r_blink <= blink_for(r_field + 2'd1);
                            r_raddr <= {r_page, r_field + 2'd1};
                        end
                    end else if (w_inc_p) begin
                        r_state <= ST_RD;
                    end
                end
                ST_RD: begin
                    r_state <= ST_WR;
                    r_we    <= 1'b1;
                    r_waddr <= {r_page, r_field};
                    r_wdata <= bcd_step(ram_r, lim_sel(r_field));
                end
                ST_WR: begin
                    r_state <= ST_EDIT;
                end
                default: begin
                    r_state <= ST_VIEW;
                    r_field <= 2'd0;
                    r_blink <= 6'd0;
                    r_edit  <= 1'b0;
                end
            endcase
        end
    end

    assign page        = r_page;
    assign blink_mask  = r_blink;
    assign edit_active = r_edit;
    assign ram_raddr   = r_raddr;
    assign ram_waddr   = r_waddr;
    assign ram_wdata   = r_wdata;
    assign ram_we      = r_we;

endmodule

// File: tb/tb_edit_ctl.sv
// Testbench for edit_ctl: directed button sequences with a write scoreboard
// and a page-sequence scoreboard, both popped by independent monitors.
`timescale 1ns/1ps

module tb_edit_ctl;

    localparam int DEB_N = 4;
    localparam int TICK  = 16;

    logic       clk;
    logic       clrn;
    logic [2:0] btn;
    logic [1:0] page;
    logic [5:0] blink_mask;
    logic       edit_active;
    logic [3:0] ram_raddr;
    logic [7:0] ram_r;
    logic [3:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic       ram_we;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wr_q[$];
    logic [1:0] page_q[$];
    int         n_tests;
    int         n_fail;

    logic [7:0] mem [16];
    logic       bw_en;
    logic [3:0] bw_addr;
    logic [7:0] bw_data;

    edit_ctl #(.DEB_N(DEB_N)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .btn         (btn),
        .page        (page),
        .blink_mask  (blink_mask),
        .edit_active (edit_active),
        .ram_raddr   (ram_raddr),
        .ram_r       (ram_r),
        .ram_waddr   (ram_waddr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous display RAM model, read-before-write; bench preload port.
    always @(posedge clk) begin
        ram_r <= mem[ram_raddr];
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end else if (bw_en) begin
            mem[bw_addr] <= bw_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_mem(input logic [3:0] a, input logic [7:0] d);
        bw_en   = 1'b1;
        bw_addr = a;
        bw_data = d;
        @(posedge clk);
        #1;
        bw_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        wr_q.push_back(e);
    endtask

    // Hold the masked buttons low, then release and let the release settle.
    task automatic press(input logic [2:0] mask, input int hold_ticks);
        btn = btn & ~mask;
        repeat (hold_ticks * TICK) @(posedge clk);
        #1;
        btn = 3'b111;
        repeat (5 * TICK) @(posedge clk);
        #1;
    endtask

    // Write monitor: every ram_we cycle must match the next expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (clrn === 1'b1 && ram_we === 1'b1) begin
                if (wr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             ram_waddr, ram_wdata);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_addr", 32'(ram_waddr), 32'(e.addr));
                    check("wr_data", 32'(ram_wdata), 32'(e.data));
                    check("rd_addr", 32'(ram_raddr), 32'(e.addr));
                end
            end
        end
    end

    // Page monitor: every page change must match the next expected page.
    initial begin
        logic [1:0] last;
        logic [1:0] exp_pg;
        last = 2'd0;
        forever begin
            @(negedge clk);
            if (page !== last) begin
                if (page_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_page: got %0d, expected no change from %0d", page, last);
                end else begin
                    exp_pg = page_q.pop_front();
                    check("page_seq", 32'(page), 32'(exp_pg));
                end
                last = page;
            end
        end
    end

    // Time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int cyc;
        n_tests = 0;
        n_fail  = 0;
        btn     = 3'b111;
        clrn    = 1'b0;
        bw_en   = 1'b0;
        bw_addr = 4'd0;
        bw_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_page",   32'(page),        32'd0);
        check("rst_blink",  32'(blink_mask),  32'd0);
        check("rst_edit",   32'(edit_active), 32'd0);
        check("rst_we",     32'(ram_we),      32'd0);
        check("rst_raddr",  32'(ram_raddr),   32'd0);
        check("rst_waddr",  32'(ram_waddr),   32'd0);
        check("rst_wdata",  32'(ram_wdata),   32'd0);
        clrn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Page wrap: five MODE presses.
        page_q.push_back(2'd1);
        page_q.push_back(2'd2);
        page_q.push_back(2'd3);
        page_q.push_back(2'd0);
        page_q.push_back(2'd1);
        for (int k = 0; k < 5; k++) press(3'b001, 4);
        check("page_after_wrap", 32'(page), 32'd1);
        check("view_edit_off",   32'(edit_active), 32'd0);

        // Edit and increment on page 1, field 0.
        set_mem(4'h4, 8'h09);
        press(3'b010, 4);
        check("edit_blink_f0", 32'(blink_mask),  32'h03);
        check("edit_active",   32'(edit_active), 32'd1);
        push_wr(4'h4, 8'h10);
        press(3'b100, 4);
        check("mem4_after_inc", 32'(mem[4]), 32'h10);

        // Bounce rejection: 8 bounce periods, then a 3-tick hold.
        push_wr(4'h4, 8'h11);
        for (int k = 0; k < 16; k++) begin
            btn[2] = ~btn[2];
            repeat (TICK / 4) @(posedge clk);
            #1;
        end
        btn[2] = 1'b0;
        repeat (3 * TICK) @(posedge clk);
        #1;
        btn = 3'b111;
        repeat (5 * TICK) @(posedge clk);
        #1;
        check("mem4_after_bounce", 32'(mem[4]), 32'h11);

        // Field 1 at its limit.
        press(3'b010, 4);
        check("edit_blink_f1", 32'(blink_mask), 32'h0C);
        set_mem(4'h5, 8'h59);
        push_wr(4'h5, 8'h00);
        press(3'b100, 4);

        // Field 2: limit, invalid BCD, decade carry.
        press(3'b010, 4);
        check("edit_blink_f2", 32'(blink_mask), 32'h30);
        set_mem(4'h6, 8'h23);
        push_wr(4'h6, 8'h00);
        press(3'b100, 4);
        set_mem(4'h6, 8'h2A);
        push_wr(4'h6, 8'h00);
        press(3'b100, 4);
        set_mem(4'h6, 8'h19);
        push_wr(4'h6, 8'h20);
        press(3'b100, 4);
        check("mem6_after_carry", 32'(mem[6]), 32'h20);
        press(3'b010, 4);
        check("exit_blink", 32'(blink_mask),  32'd0);
        check("exit_edit",  32'(edit_active), 32'd0);

        // MODE together with INC in EDIT aborts with no write.
        press(3'b010, 4);
        check("reenter_edit", 32'(edit_active), 32'd1);
        press(3'b101, 4);
        check("abort_edit",  32'(edit_active), 32'd0);
        check("abort_blink", 32'(blink_mask),  32'd0);
        check("abort_page",  32'(page),        32'd1);

        // A long INC hold still gives a single write.
        press(3'b010, 4);
        push_wr(4'h4, 8'h12);
        press(3'b100, 10);
        check("mem4_after_hold", 32'(mem[4]), 32'h12);

        // Reset while the write strobe is up: no write completes.
        btn[2] = 1'b0;
        cyc = 0;
        while (ram_we !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("we_before_reset", 32'(ram_we), 32'd1);
        page_q.push_back(2'd0);
        clrn = 1'b0;
        #1;
        check("midrst_we",    32'(ram_we),      32'd0);
        check("midrst_page",  32'(page),        32'd0);
        check("midrst_blink", 32'(blink_mask),  32'd0);
        check("midrst_edit",  32'(edit_active), 32'd0);
        check("midrst_waddr", 32'(ram_waddr),   32'd0);
        check("midrst_wdata", 32'(ram_wdata),   32'd0);
        btn = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        check("mem4_no_partial", 32'(mem[4]), 32'h12);
        clrn = 1'b1;
        repeat (5 * TICK) @(posedge clk);
        #1;
        check("post_rst_page",  32'(page),       32'd0);
        check("post_rst_blink", 32'(blink_mask), 32'd0);

        check("wr_q_empty",   32'(wr_q.size()),   32'd0);
        check("page_q_empty", 32'(page_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
